// File: rtl/relay_pulse_driver_pkg.sv
// Shared types and sizing helpers for the relay pulse driver.
package relay_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OPERATE,
        HOLD,
        RELEASE,
        GAP
    } drv_state_e;

    function automatic int ms_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/relay_pulse_driver_if.sv
// Pulse request handshake between a sequencer client and the driver.
interface relay_pulse_driver_if #(
    parameter int SW = 3
);
    logic          req_valid;
    logic [SW-1:0] req_sel;
    logic          req_ready;

    modport master (
        output req_valid,
        output req_sel,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_sel,
        output req_ready
    );
endinterface

// File: rtl/relay_pulse_driver_ms_timer.sv
// Millisecond down-counter; expires on a tick while holding 1.
module ms_timer #(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_ms,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expire
);

    logic [CW-1:0] r_ctr;

    // A load wins over a coincident tick, so the load cycle is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctr <= '0;
        end else if (load) begin
            r_ctr <= load_val;
        end else if (tick_ms && (r_ctr != '0)) begin
            r_ctr <= r_ctr - 1'b1;
        end
    end

    assign expire = tick_ms && (r_ctr == CW'(1));

endmodule

// File: rtl/relay_pulse_driver.sv
// Sequences one relay pulse: operate check, hold, release check, gap.
module relay_pulse_driver
    import relay_pkg::*;
#(
    parameter int NRELAY  = 8,
    parameter int HOLD_MS = 15,
    parameter int GAP_MS  = 5,
    parameter int TMO_MS  = 50,
    parameter int SW      = $clog2(NRELAY)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_ms,
    relay_pulse_driver_if.slave req,
    output logic [NRELAY-1:0] pick,
    input  logic [NRELAY-1:0] pulled,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [SW-1:0]     fault_sel
);

    localparam int CW = ms_width(max3(TMO_MS, HOLD_MS, GAP_MS));

    drv_state_e        r_state, w_state;
    logic [SW-1:0]     r_sel, w_sel;
    logic [NRELAY-1:0] r_pick, w_pick;
    logic              r_done, w_done;
    logic              r_fault, w_fault;
    logic [SW-1:0]     r_fsel, w_fsel;
    logic              w_load;
    logic [CW-1:0]     w_load_val;
    logic              w_expire;
    logic              w_accept;
    logic              w_bad;
    logic              w_pulled;

    assign w_accept = req.req_valid && (r_state == IDLE);
    assign w_bad    = {1'b0, req.req_sel} >= (SW + 1)'(NRELAY);
    assign w_pulled = pulled[r_sel];

    ms_timer #(
        .CW(CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick_ms  (tick_ms),
        .load     (w_load),
        .load_val (w_load_val),
        .expire   (w_expire)
    );

    always_comb begin
        w_state    = r_state;
        w_sel      = r_sel;
        w_pick     = r_pick;
        w_done     = 1'b0;
        w_fault    = 1'b0;
        w_fsel     = r_fsel;
        w_load     = 1'b0;
        w_load_val = '0;
        unique case (r_state)
            IDLE: begin
                if (w_accept && w_bad) begin
                    w_fault = 1'b1;
                    w_done  = 1'b1;
                    w_fsel  = req.req_sel;
                end else if (w_accept) begin
                    w_sel      = req.req_sel;
                    w_pick     = NRELAY'(1) << req.req_sel;
                    w_load     = 1'b1;
                    w_load_val = CW'(TMO_MS);
                    w_state    = OPERATE;
                end
            end
            OPERATE: begin
                if (w_pulled) begin
                    w_load     = 1'b1;
                    w_load_val = CW'(HOLD_MS);
                    w_state    = HOLD;
                end else if (w_expire) begin
                    w_fault    = 1'b1;
                    w_fsel     = r_sel;
                    w_pick     = '0;
                    w_load     = 1'b1;
                    w_load_val = CW'(TMO_MS);
                    w_state    = RELEASE;
                end
            end
            HOLD: begin
                if (!w_pulled || w_expire) begin
                    w_fault    = !w_pulled;
                    w_fsel     = w_pulled ? r_fsel : r_sel;
                    w_pick     = '0;
                    w_load     = 1'b1;
                    w_load_val = CW'(TMO_MS);
                    w_state    = RELEASE;
                end
            end
            RELEASE: begin
                // A release seen on the timeout tick still counts as clean.
                if (!w_pulled || w_expire) begin
                    w_fault    = w_pulled;
                    w_fsel     = w_pulled ? r_sel : r_fsel;
                    w_load     = 1'b1;
                    w_load_val = CW'(GAP_MS);
                    w_state    = GAP;
                end
            end
            GAP: begin
                if (w_expire) begin
                    w_done  = 1'b1;
                    w_state = IDLE;
                end
            end
            default: begin
                w_pick  = '0;
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_pick  <= '0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            r_fsel  <= '0;
        end else begin
            r_state <= w_state;
            r_sel   <= w_sel;
            r_pick  <= w_pick;
            r_done  <= w_done;
            r_fault <= w_fault;
            r_fsel  <= w_fsel;
        end
    end

    assign req.req_ready = (r_state == IDLE);
    assign busy          = (r_state != IDLE);
    assign pick          = r_pick;
    assign done          = r_done;
    assign fault         = r_fault;
    assign fault_sel     = r_fsel;

endmodule

// File: tb/tb_relay_pulse_driver.sv
// Directed bench for relay_pulse_driver with bench-driven ms ticks.
module tb_relay_pulse_driver;

    localparam int NR = 6;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick_ms = 1'b0;
    logic [NR-1:0] pulled = '0;
    logic [NR-1:0] pick;
    logic          busy;
    logic          done;
    logic          fault;
    logic [SW-1:0] fault_sel;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_fault = 0;
    int n_bad = 0;
    logic [NR-1:0] exp_mask = '0;

    relay_pulse_driver_if #(.SW(SW)) rif ();

    relay_pulse_driver #(
        .NRELAY  (NR),
        .HOLD_MS (15),
        .GAP_MS  (5),
        .TMO_MS  (50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_ms   (tick_ms),
        .req       (rif.slave),
        .pick      (pick),
        .pulled    (pulled),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .fault_sel (fault_sel)
    );

    always #5 clk = ~clk;

    // Pre-edge values: pulses and any pick bit outside the expected mask.
    always @(posedge clk) begin
        if (!rst) begin
            if (done) n_done++;
            if (fault) n_fault++;
            if ((pick & ~exp_mask) != '0) n_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ms(input int n);
        repeat (n) begin
            idle(2);
            tick_ms = 1'b1;
            @(negedge clk);
            tick_ms = 1'b0;
        end
    endtask

    task automatic request(input logic [SW-1:0] sel);
        rif.req_sel   = sel;
        rif.req_valid = 1'b1;
        @(negedge clk);
        rif.req_valid = 1'b0;
    endtask

    initial begin
        rif.req_valid = 1'b0;
        rif.req_sel   = '0;
        idle(3);
        chk("rst_pick", 32'(pick), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_fsel", 32'(fault_sel), 32'h0);
        chk("rst_ready", 32'(rif.req_ready), 32'h1);
        rst = 1'b0;
        idle(2);

        // Normal pulse on relay 3: operate 20 ms, release 10 ms
        exp_mask = 6'b001000;
        request(3'd3);
        chk("t1_pick", 32'(pick), 32'h08);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_ready", 32'(rif.req_ready), 32'h0);
        ms(20);
        chk("t1_oper", 32'(pick), 32'h08);
        pulled[3] = 1'b1;
        idle(1);
        ms(14);
        chk("t1_hold14", 32'(pick), 32'h08);
        ms(1);
        chk("t1_hold15", 32'(pick), 32'h0);
        ms(10);
        pulled[3] = 1'b0;
        idle(1);
        ms(4);
        chk("t1_gap_busy", 32'(busy), 32'h1);
        chk("t1_gap_done", 32'(done), 32'h0);
        ms(1);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_nofault", 32'(fault), 32'h0);
        chk("t1_ready2", 32'(rif.req_ready), 32'h1);
        idle(1);
        chk("t1_ndone", 32'(n_done), 32'd1);
        chk("t1_nfault", 32'(n_fault), 32'd0);

        // Relay 1 never operates: timeout fault
        exp_mask = 6'b000010;
        request(3'd1);
        ms(49);
        chk("t2_pre_pick", 32'(pick), 32'h02);
        chk("t2_pre_fault", 32'(fault), 32'h0);
        ms(1);
        chk("t2_fault", 32'(fault), 32'h1);
        chk("t2_fsel", 32'(fault_sel), 32'h1);
        chk("t2_pick", 32'(pick), 32'h0);
        idle(1);
        chk("t2_onepulse", 32'(fault), 32'h0);
        ms(5);
        chk("t2_done", 32'(done), 32'h1);
        idle(1);
        chk("t2_nfault", 32'(n_fault), 32'd1);
        chk("t2_ndone", 32'(n_done), 32'd2);

        // Drop of relay 2 five ms into hold
        exp_mask = 6'b000100;
        request(3'd2);
        ms(3);
        pulled[2] = 1'b1;
        idle(1);
        ms(5);
        pulled[2] = 1'b0;
        idle(1);
        chk("t3_fault", 32'(fault), 32'h1);
        chk("t3_fsel", 32'(fault_sel), 32'h2);
        chk("t3_pick", 32'(pick), 32'h0);
        idle(1);
        ms(5);
        chk("t3_done", 32'(done), 32'h1);
        idle(1);
        chk("t3_nfault", 32'(n_fault), 32'd2);

        // Out-of-range select
        exp_mask = '0;
        request(3'd7);
        chk("t4_fault", 32'(fault), 32'h1);
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_fsel", 32'(fault_sel), 32'h7);
        chk("t4_pick", 32'(pick), 32'h0);
        chk("t4_ready", 32'(rif.req_ready), 32'h1);
        idle(1);
        chk("t4_fault_off", 32'(fault), 32'h0);
        chk("t4_busy", 32'(busy), 32'h0);

        // Back-to-back: second request held waiting on relay 5
        exp_mask = 6'b010000;
        rif.req_sel   = 3'd4;
        rif.req_valid = 1'b1;
        @(negedge clk);
        rif.req_sel = 3'd5;
        chk("t5_pick", 32'(pick), 32'h10);
        chk("t5_ready", 32'(rif.req_ready), 32'h0);
        ms(2);
        pulled[4] = 1'b1;
        idle(1);
        ms(15);
        chk("t5_hold_end", 32'(pick), 32'h0);
        ms(3);
        pulled[4] = 1'b0;
        exp_mask = '0;
        idle(1);
        ms(4);
        chk("t5_gap_ready", 32'(rif.req_ready), 32'h0);
        ms(1);
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_ready2", 32'(rif.req_ready), 32'h1);
        chk("t5_gap_pick", 32'(pick), 32'h0);
        exp_mask = 6'b100000;
        @(negedge clk);
        rif.req_valid = 1'b0;
        chk("t5_accept2", 32'(pick), 32'h20);
        chk("t5_busy2", 32'(busy), 32'h1);
        chk("t5_done_off", 32'(done), 32'h0);

        // Reset while relay 5 is in hold
        ms(1);
        pulled[5] = 1'b1;
        idle(1);
        ms(3);
        chk("t6_in_hold", 32'(pick), 32'h20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_pick", 32'(pick), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_ready", 32'(rif.req_ready), 32'h1);
        chk("t6_fsel", 32'(fault_sel), 32'h0);
        pulled[5] = 1'b0;
        idle(3);
        chk("t6_ndone", 32'(n_done), 32'd5);
        chk("t6_nfault", 32'(n_fault), 32'd3);

        // Pulled arrives on the very timeout tick: no fault
        exp_mask = 6'b000001;
        request(3'd0);
        ms(49);
        idle(2);
        tick_ms   = 1'b1;
        pulled[0] = 1'b1;
        @(negedge clk);
        tick_ms = 1'b0;
        chk("t7_nofault", 32'(fault), 32'h0);
        chk("t7_pick", 32'(pick), 32'h01);
        ms(15);
        chk("t7_hold_end", 32'(pick), 32'h0);
        pulled[0] = 1'b0;
        idle(1);
        ms(5);
        chk("t7_done", 32'(done), 32'h1);
        idle(1);
        chk("t7_ndone", 32'(n_done), 32'd6);
        chk("t7_nfault", 32'(n_fault), 32'd3);
        chk("stray_pick", 32'(n_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
